// File: rtl/snn_fifo_pkg.sv
// rtl/snn_fifo_pkg.sv - shared depths and status-window count widths for the SNN core FIFOs
// Contents: IN_FIFO_DEPTH/OUT_FIFO_DEPTH and the matching occupancy count widths.
package snn_fifo_pkg;

    localparam int IN_FIFO_DEPTH  = 512;
    localparam int OUT_FIFO_DEPTH = 256;

    // Count must represent 0..DEPTH inclusive, hence DEPTH+1.
    localparam int IN_CNT_W  = $clog2(IN_FIFO_DEPTH + 1);
    localparam int OUT_CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

endpackage

// File: rtl/fifo_mem_sdp.sv
// rtl/fifo_mem_sdp.sv - simple dual-port storage, one write port and one registered read port
// Ports: clk, rst (async, active-high, read register only), we/waddr/wdata write port,
//        re/raddr read request, rdata registered read data (holds when re is low).
module fifo_mem_sdp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    // Array carries no reset so it can be swapped for an SRAM macro.
    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-address write this edge is not seen by the read,
    // which is what a full FIFO doing push+pop together needs.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/snn_sync_fifo.sv
// rtl/snn_sync_fifo.sv - single-clock FIFO with occupancy count, empty/full and optional sticky error flags
// Ports: clk, rst (async, active-high), flush (sync clear), push/wdata, pop,
//        rdata/rvalid (1-cycle read latency), count, empty, full.
// Macro SNN_FIFO_ERR_FLAGS_EN adds overflow, underflow (sticky) and err_clr.
module snn_sync_fifo
    import snn_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = IN_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
`ifdef SNN_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rvalid_q, rvalid_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags come straight off the count register, never off the request inputs.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    // On empty the pop is refused even if a push arrives: there is no bypass.
    assign push_ok = !flush && push && (!full || pop);
    assign pop_ok  = !flush && pop && !empty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rvalid_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by plain overflow.
            if (push_ok) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_d   = rptr_q + PTR_W'(1);
                rvalid_d = 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    fifo_mem_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (push_ok),
        .waddr(wptr_q),
        .wdata(wdata),
        .re   (pop_ok),
        .raddr(rptr_q),
        .rdata(rdata)
    );

    assign rvalid = rvalid_q;
    assign count  = count_q;

`ifdef SNN_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Flush discards the requests, so they do not count as errors.
    // Clear is applied first so a same-cycle new error wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && push && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (!flush && pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_snn_sync_fifo.sv
// tb/tb_snn_sync_fifo.sv - randomized self-checking bench for snn_sync_fifo at DEPTH 512 and DEPTH 4
module tb_snn_sync_fifo;

    localparam int W  = 32;
    localparam int BD = 512;
    localparam int SD = 4;

    logic clk;
    logic rst;

    // DEPTH 512 instance
    logic          b_flush, b_push, b_pop;
    logic [W-1:0]  b_wdata, b_rdata;
    logic          b_rvalid, b_empty, b_full;
    logic [9:0]    b_count;

    // DEPTH 4 instance
    logic          s_flush, s_push, s_pop;
    logic [W-1:0]  s_wdata, s_rdata;
    logic          s_rvalid, s_empty, s_full;
    logic [2:0]    s_count;

`ifdef SNN_FIFO_ERR_FLAGS_EN
    logic b_ovf, b_udf, b_err_clr;
    logic s_ovf, s_udf, s_err_clr;
    logic m_ovf, m_udf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of stored words plus the last read result.
    logic [W-1:0] q[$];
    logic [W-1:0] m_rdata;
    logic         m_rvalid;

    snn_sync_fifo #(.WIDTH(W), .DEPTH(BD)) u_big (
        .clk(clk), .rst(rst), .flush(b_flush), .push(b_push), .wdata(b_wdata),
        .pop(b_pop), .rdata(b_rdata), .rvalid(b_rvalid), .count(b_count),
        .empty(b_empty), .full(b_full)
`ifdef SNN_FIFO_ERR_FLAGS_EN
        , .overflow(b_ovf), .underflow(b_udf), .err_clr(b_err_clr)
`endif
    );

    snn_sync_fifo #(.WIDTH(W), .DEPTH(SD)) u_small (
        .clk(clk), .rst(rst), .flush(s_flush), .push(s_push), .wdata(s_wdata),
        .pop(s_pop), .rdata(s_rdata), .rvalid(s_rvalid), .count(s_count),
        .empty(s_empty), .full(s_full)
`ifdef SNN_FIFO_ERR_FLAGS_EN
        , .overflow(s_ovf), .underflow(s_udf), .err_clr(s_err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle on the small FIFO: drive, update the model, sample 1 time unit after the edge.
    task automatic s_cycle(input logic p, input logic o, input logic f, input logic [W-1:0] d);
        int n;
        n = q.size();
        s_push = p; s_pop = o; s_flush = f; s_wdata = d;
        if (f) begin
            q.delete();
            m_rvalid = 1'b0;
        end else begin
`ifdef SNN_FIFO_ERR_FLAGS_EN
            if (p && !o && n == SD) m_ovf = 1'b1;
            if (o && n == 0) m_udf = 1'b1;
`endif
            m_rvalid = o && (n > 0);
            if (m_rvalid) m_rdata = q.pop_front();
            if (p && (n < SD || o)) q.push_back(d);
        end
        @(posedge clk);
        #1;
        s_push = 1'b0; s_pop = 1'b0; s_flush = 1'b0;
    endtask

    task automatic test_reset;
        n_checks += 6;
        if (s_count !== 3'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_small_flags count=%0d empty=%b full=%b want 0/1/0", s_count, s_empty, s_full);
        end
        if (s_rvalid !== 1'b0 || s_rdata !== '0) begin
            n_fail++; $display("FAIL reset_small_read rvalid=%b rdata=%h want 0/0", s_rvalid, s_rdata);
        end
        if (b_count !== 10'd0 || b_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_big_count count=%0d empty=%b want 0/1", b_count, b_empty);
        end
        if (b_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_big_full full=%b want 0", b_full);
        end
        if (b_rvalid !== 1'b0 || b_rdata !== '0) begin
            n_fail++; $display("FAIL reset_big_read rvalid=%b rdata=%h want 0/0", b_rvalid, b_rdata);
        end
`ifdef SNN_FIFO_ERR_FLAGS_EN
        if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags ovf=%b udf=%b want 0/0", s_ovf, s_udf);
        end
`else
        if (s_pop !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle pop=%b want 0", s_pop);
        end
`endif
    endtask

    task automatic test_fill_drain_512;
        for (int i = 0; i < BD; i++) begin
            b_push = 1'b1; b_wdata = W'(i);
            @(posedge clk); #1;
            n_checks++;
            if (b_count !== 10'(i + 1)) begin
                n_fail++; $display("FAIL fill512_count got=%0d want=%0d", b_count, i + 1);
            end
        end
        b_push = 1'b0;
        n_checks++;
        if (b_full !== 1'b1 || b_empty !== 1'b0) begin
            n_fail++; $display("FAIL fill512_full full=%b empty=%b want 1/0", b_full, b_empty);
        end
        for (int i = 0; i < BD; i++) begin
            b_pop = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (b_rvalid !== 1'b1 || b_rdata !== W'(i)) begin
                n_fail++; $display("FAIL drain512_data rvalid=%b rdata=%0d want 1/%0d", b_rvalid, b_rdata, i);
            end
        end
        b_pop = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (b_empty !== 1'b1 || b_count !== 10'd0 || b_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL drain512_empty empty=%b count=%0d rvalid=%b want 1/0/0", b_empty, b_count, b_rvalid);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < SD; i++) s_cycle(1'b1, 1'b0, 1'b0, $urandom);
        n_checks++;
        if (s_count !== 3'd4 || s_full !== 1'b1) begin
            n_fail++; $display("FAIL full_fill count=%0d full=%b want 4/1", s_count, s_full);
        end
        for (int i = 0; i < 3; i++) begin
            s_cycle(1'b1, 1'b1, 1'b0, $urandom);
            n_checks++;
            if (s_count !== 3'd4 || s_full !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== m_rdata) begin
                n_fail++; $display("FAIL full_pushpop count=%0d full=%b rvalid=%b rdata=%h want 4/1/1/%h",
                                   s_count, s_full, s_rvalid, s_rdata, m_rdata);
            end
        end
        for (int i = 0; i < SD; i++) begin
            s_cycle(1'b0, 1'b1, 1'b0, '0);
            n_checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== m_rdata) begin
                n_fail++; $display("FAIL full_order rvalid=%b rdata=%h want 1/%h", s_rvalid, s_rdata, m_rdata);
            end
        end
    endtask

    task automatic test_empty_push_pop;
        s_cycle(1'b1, 1'b1, 1'b0, 32'hA5);
        n_checks++;
        if (s_count !== 3'd1 || s_rvalid !== 1'b0 || s_empty !== 1'b0) begin
            n_fail++; $display("FAIL empty_pushpop count=%0d rvalid=%b empty=%b want 1/0/0", s_count, s_rvalid, s_empty);
        end
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hA5) begin
            n_fail++; $display("FAIL empty_next_pop rvalid=%b rdata=%h want 1/a5", s_rvalid, s_rdata);
        end
`ifdef SNN_FIFO_ERR_FLAGS_EN
        s_err_clr = 1'b1; @(posedge clk); #1; s_err_clr = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
`endif
    endtask

    task automatic test_push_full_drop;
        for (int i = 0; i < SD; i++) s_cycle(1'b1, 1'b0, 1'b0, 32'h100 + W'(i));
        s_cycle(1'b1, 1'b0, 1'b0, 32'hDEAD);
        n_checks++;
        if (s_count !== 3'd4 || s_full !== 1'b1) begin
            n_fail++; $display("FAIL overpush_count count=%0d full=%b want 4/1", s_count, s_full);
        end
`ifdef SNN_FIFO_ERR_FLAGS_EN
        s_cycle(1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (s_ovf !== 1'b1) begin
            n_fail++; $display("FAIL overflow_sticky ovf=%b want 1", s_ovf);
        end
        s_err_clr = 1'b1; @(posedge clk); #1; s_err_clr = 1'b0;
        m_ovf = 1'b0;
        n_checks++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clear ovf=%b want 0", s_ovf);
        end
`endif
        for (int i = 0; i < SD; i++) begin
            s_cycle(1'b0, 1'b1, 1'b0, '0);
            n_checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h100 + W'(i)) begin
                n_fail++; $display("FAIL overpush_data rdata=%h want %h", s_rdata, 32'h100 + i);
            end
        end
        n_checks++;
        if (s_empty !== 1'b1) begin
            n_fail++; $display("FAIL overpush_empty empty=%b want 1", s_empty);
        end
    endtask

    task automatic test_pop_empty;
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (s_rvalid !== 1'b0 || s_rdata !== 32'h103 || s_count !== 3'd0) begin
            n_fail++; $display("FAIL pop_empty rvalid=%b rdata=%h count=%0d want 0/103/0", s_rvalid, s_rdata, s_count);
        end
`ifdef SNN_FIFO_ERR_FLAGS_EN
        n_checks++;
        if (s_udf !== 1'b1) begin
            n_fail++; $display("FAIL underflow_set udf=%b want 1", s_udf);
        end
        s_err_clr = 1'b1; @(posedge clk); #1; s_err_clr = 1'b0;
        m_udf = 1'b0;
`endif
    endtask

    task automatic test_wrap;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) s_cycle(1'b1, 1'b0, 1'b0, $urandom);
            n_checks++;
            if (s_count !== 3'd3) begin
                n_fail++; $display("FAIL wrap_count round=%0d count=%0d want 3", r, s_count);
            end
            for (int i = 0; i < 3; i++) begin
                s_cycle(1'b0, 1'b1, 1'b0, '0);
                n_checks++;
                if (s_rvalid !== 1'b1 || s_rdata !== m_rdata) begin
                    n_fail++; $display("FAIL wrap_data round=%0d rdata=%h want %h", r, s_rdata, m_rdata);
                end
            end
        end
    endtask

    task automatic test_flush;
        logic [W-1:0] held;
        for (int i = 0; i < SD; i++) s_cycle(1'b1, 1'b0, 1'b0, $urandom);
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        held = m_rdata;
        s_cycle(1'b1, 1'b1, 1'b1, 32'hBEEF);
        n_checks++;
        if (s_count !== 3'd0 || s_empty !== 1'b1 || s_rvalid !== 1'b0 || s_rdata !== held) begin
            n_fail++; $display("FAIL flush count=%0d empty=%b rvalid=%b rdata=%h want 0/1/0/%h",
                               s_count, s_empty, s_rvalid, s_rdata, held);
        end
        s_cycle(1'b1, 1'b0, 1'b0, 32'h1234_5678);
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h1234_5678) begin
            n_fail++; $display("FAIL flush_reuse rvalid=%b rdata=%h want 1/12345678", s_rvalid, s_rdata);
        end
    endtask

    task automatic test_random;
        logic p, o, f;
        for (int i = 0; i < 400; i++) begin
            p = $urandom_range(0, 1) == 1;
            o = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 31) == 0;
            if (i % 50 < 20) o = $urandom_range(0, 3) == 0;
            s_cycle(p, o, f, $urandom);
            n_checks++;
            if (s_count !== 3'(q.size()) || s_empty !== (q.size() == 0) || s_full !== (q.size() == SD) ||
                s_rvalid !== m_rvalid || s_rdata !== m_rdata) begin
                n_fail++; $display("FAIL random i=%0d count=%0d empty=%b full=%b rvalid=%b rdata=%h want %0d/%b/%b/%b/%h",
                                   i, s_count, s_empty, s_full, s_rvalid, s_rdata,
                                   q.size(), q.size() == 0, q.size() == SD, m_rvalid, m_rdata);
            end
`ifdef SNN_FIFO_ERR_FLAGS_EN
            n_checks++;
            if (s_ovf !== m_ovf || s_udf !== m_udf) begin
                n_fail++; $display("FAIL random_flags ovf=%b udf=%b want %b/%b", s_ovf, s_udf, m_ovf, m_udf);
            end
`endif
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) s_cycle(1'b1, 1'b0, 1'b0, 32'hC0DE_0000 + W'(i));
        s_cycle(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        b_push = 1'b1; b_wdata = 32'h77;
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        b_push = 1'b0;
        // Now mid-cycle, well before the next rising edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks += 2;
        if (s_count !== 3'd0 || s_empty !== 1'b1 || s_full !== 1'b0 || s_rvalid !== 1'b0 || s_rdata !== '0) begin
            n_fail++; $display("FAIL async_rst_small count=%0d empty=%b full=%b rvalid=%b rdata=%h want 0/1/0/0/0",
                               s_count, s_empty, s_full, s_rvalid, s_rdata);
        end
        if (b_count !== 10'd0 || b_empty !== 1'b1) begin
            n_fail++; $display("FAIL async_rst_big count=%0d empty=%b want 0/1", b_count, b_empty);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete(); m_rdata = '0; m_rvalid = 1'b0;
        s_cycle(1'b1, 1'b0, 1'b0, 32'h5A5A);
        s_cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h5A5A || s_count !== 3'd0) begin
            n_fail++; $display("FAIL post_rst rvalid=%b rdata=%h count=%0d want 1/5a5a/0", s_rvalid, s_rdata, s_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_wdata = '0;
        s_flush = 1'b0; s_push = 1'b0; s_pop = 1'b0; s_wdata = '0;
`ifdef SNN_FIFO_ERR_FLAGS_EN
        b_err_clr = 1'b0; s_err_clr = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
`endif
        m_rdata = '0; m_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fill_drain_512();
        test_full_push_pop();
        test_empty_push_pop();
        test_push_full_drop();
        test_pop_empty();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
